// File: rtl/chunked_adder_sequencer.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit ripple slice per cycle, LSB chunk first.
// Optional feature macro: SUBTRACT_EN adds a sub port (a - b via ~b plus carry-in 1).
module chunked_adder_sequencer #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   o_sum,
    output logic             o_busy,
    output logic [1:0]       state_dbg
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready, and ready/valid here come only
    // from the state register.

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [CHUNK:0]   slice_sum;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;

    always_comb begin
        slice_a   = op_a[int'(idx)*CHUNK +: CHUNK];
        slice_b   = op_b[int'(idx)*CHUNK +: CHUNK];
        slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry};
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign o_busy    = (state == RUN) || (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            o_sum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        idx   <= '0;
                        state <= RUN;
`ifdef SUBTRACT_EN
                        op_b  <= sub ? ~b : b;
                        carry <= sub;
`else
                        op_b  <= b;
                        carry <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    o_sum[int'(idx)*CHUNK +: CHUNK] <= slice_sum[CHUNK-1:0];
                    carry <= slice_sum[CHUNK];
                    // The counter stops at the last chunk; only acceptance or reset rewinds it.
                    if (idx == LAST_IDX) begin
                        o_sum[WIDTH] <= slice_sum[CHUNK];
                        state        <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
